// File: rtl/tft_user_scan_io.sv
// ---------------------------------------------------------------------------
// tft_user_scan_io
//
// Purpose: user-side address scanner and host data pad for the TFT path.
//   - Bidirectional 16-bit host pad (DATA), driven from dq_out when dq_oe=1
//     and read back combinationally on dq_in.
//   - 10-bit column and 9-bit row counters walking a programmable
//     rectangular window, either column-fast (row_col_inc=0) or row-fast
//     (row_col_inc=1). The fast counter steps once per startup_inc cycle.
//     At its end value it reloads its start value and steps the slow
//     counter. The slow counter reloads at its own end, so the scan wraps
//     to (colS,rowS).
//
// Ports:
//   osc_clk             system clock, rising edge
//   RST                 async active-low reset (synchronised release inside)
//   DATA[15:0]          host data pad (inout)
//   dq_oe, dq_out       pad drive enable / drive value
//   dq_in               pad read-back (combinational)
//   col_add_S/E         column window start/end (sampled live)
//   row_add_S/E         row window start/end (sampled live)
//   update_col_row_add  load both counters with their start values
//   row_col_inc         0 = column-fast, 1 = row-fast
//   startup_inc         one address step per cycle while high
//   col_add, row_add    current address
//   col_cnt_end,
//   row_cnt_end         counter == end value (combinational)
//   frame_done          one-cycle pulse after the last window address steps
//
// Configuration:
//   USER_SCAN_FRAME_DONE_EN  defined   -> frame_done is generated
//                            undefined -> frame_done tied to 0, flop removed
// ---------------------------------------------------------------------------

// Single wrap-around counter with load-over-enable priority.
module tft_scan_cnt #(
  parameter int W = 10
) (
  input  logic         osc_clk,
  input  logic         rst_n,
  input  logic         ld,
  input  logic         en,
  input  logic [W-1:0] start,
  output logic [W-1:0] q
);
  logic [W-1:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (ld)      q_d = start;
    else if (en) q_d = q_q + {{(W-1){1'b0}}, 1'b1}; // natural 2^W wrap
  end

  always_ff @(posedge osc_clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;
endmodule

module tft_user_scan_io (
  input  logic        osc_clk,
  input  logic        RST,
  inout  wire  [15:0] DATA,
  input  logic        dq_oe,
  input  logic [15:0] dq_out,
  output logic [15:0] dq_in,
  input  logic [9:0]  col_add_S,
  input  logic [9:0]  col_add_E,
  input  logic [8:0]  row_add_S,
  input  logic [8:0]  row_add_E,
  input  logic        update_col_row_add,
  input  logic        row_col_inc,
  input  logic        startup_inc,
  output logic [9:0]  col_add,
  output logic [8:0]  row_add,
  output logic        col_cnt_end,
  output logic        row_cnt_end,
  output logic        frame_done
);

  // -------------------------------------------------------------------------
  // Pad
  // -------------------------------------------------------------------------
  assign DATA  = dq_oe ? dq_out : 16'bz;
  assign dq_in = DATA;

  // -------------------------------------------------------------------------
  // Reset: assertion reaches the flops immediately, release is re-timed to
  // osc_clk so no counter sees a release close to an edge.
  // -------------------------------------------------------------------------
  logic [1:0] rst_sync_d, rst_sync_q;
  logic       rst_n;

  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge osc_clk or negedge RST) begin
    if (!RST) rst_sync_q <= '0;
    else      rst_sync_q <= rst_sync_d;
  end

  assign rst_n = rst_sync_q[1];

  // -------------------------------------------------------------------------
  // Step / load control
  // -------------------------------------------------------------------------
  logic col_en, row_en, col_ld, row_ld;

  assign col_cnt_end = (col_add == col_add_E);
  assign row_cnt_end = (row_add == row_add_E);

  // The fast counter steps on every enabled cycle. The slow counter steps
  // only when the fast one is at its end.
  assign col_en = (~row_col_inc | row_cnt_end) & startup_inc;
  assign row_en = ( row_col_inc | col_cnt_end) & startup_inc;

  // Reaching the end while stepping reloads the start value instead of
  // incrementing. An explicit update wins over any step.
  assign col_ld = update_col_row_add | (col_cnt_end & col_en);
  assign row_ld = update_col_row_add | (row_cnt_end & row_en);

  tft_scan_cnt #(.W(10)) u_col_cnt (
    .osc_clk (osc_clk),
    .rst_n   (rst_n),
    .ld      (col_ld),
    .en      (col_en),
    .start   (col_add_S),
    .q       (col_add)
  );

  tft_scan_cnt #(.W(9)) u_row_cnt (
    .osc_clk (osc_clk),
    .rst_n   (rst_n),
    .ld      (row_ld),
    .en      (row_en),
    .start   (row_add_S),
    .q       (row_add)
  );

  // -------------------------------------------------------------------------
  // Frame-done pulse: the step taken from (colE,rowE) is the last address of
  // the window. In both modes the column is enabled on that step, so one
  // term covers both scan orders.
  // -------------------------------------------------------------------------
`ifdef USER_SCAN_FRAME_DONE_EN
  logic frame_done_d, frame_done_q;

  always_comb frame_done_d = col_en & col_cnt_end & row_cnt_end;

  always_ff @(posedge osc_clk or negedge rst_n) begin
    if (!rst_n) frame_done_q <= 1'b0;
    else        frame_done_q <= frame_done_d;
  end

  assign frame_done = frame_done_q;
`else
  assign frame_done = 1'b0;
`endif

endmodule

// File: tb/tb_tft_user_scan_io.sv
module tb_tft_user_scan_io;

`ifdef USER_SCAN_FRAME_DONE_EN
  localparam bit FD_EN = 1'b1;
`else
  localparam bit FD_EN = 1'b0;
`endif

  logic        osc_clk = 1'b0;
  logic        RST;
  wire  [15:0] DATA;
  logic        dq_oe;
  logic [15:0] dq_out;
  wire  [15:0] dq_in;
  logic [9:0]  cs, ce;
  logic [8:0]  rs, re;
  logic        upd, mode, inc;
  wire  [9:0]  col_add;
  wire  [8:0]  row_add;
  wire         col_cnt_end, row_cnt_end, frame_done;

  logic        ext_oe;
  logic [15:0] ext_val;
  assign DATA = ext_oe ? ext_val : 16'bz;

  always #5 osc_clk = ~osc_clk;

  tft_user_scan_io dut (
    .osc_clk            (osc_clk),
    .RST                (RST),
    .DATA               (DATA),
    .dq_oe              (dq_oe),
    .dq_out             (dq_out),
    .dq_in              (dq_in),
    .col_add_S          (cs),
    .col_add_E          (ce),
    .row_add_S          (rs),
    .row_add_E          (re),
    .update_col_row_add (upd),
    .row_col_inc        (mode),
    .startup_inc        (inc),
    .col_add            (col_add),
    .row_add            (row_add),
    .col_cnt_end        (col_cnt_end),
    .row_cnt_end        (row_cnt_end),
    .frame_done         (frame_done)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: current window address and the frame pulse.
  int m_col = 0;
  int m_row = 0;
  bit m_fd  = 1'b0;

  // Advance one clock, moving the model by the scan rules using the inputs
  // that are present at the edge. Returns #1 after the rising edge.
  task automatic clk_step();
    int nc, nr;
    bit fd;
    fd = inc && (m_col == int'(ce)) && (m_row == int'(re));
    nc = m_col;
    nr = m_row;
    if (upd) begin
      nc = cs; nr = rs;
    end else if (inc) begin
      if (!mode) begin
        if (m_col == int'(ce)) begin
          nc = cs;
          nr = (m_row == int'(re)) ? int'(rs) : (m_row + 1) % 512;
        end else nc = (m_col + 1) % 1024;
      end else begin
        if (m_row == int'(re)) begin
          nr = rs;
          nc = (m_col == int'(ce)) ? int'(cs) : (m_col + 1) % 1024;
        end else nr = (m_row + 1) % 512;
      end
    end
    @(posedge osc_clk);
    #1;
    m_col = nc;
    m_row = nr;
    m_fd  = fd & FD_EN;
  endtask

  task automatic test_reset();
    RST = 1'b0; upd = 0; inc = 0; mode = 0;
    dq_oe = 0; dq_out = '0; ext_oe = 0; ext_val = '0;
    cs = 0; ce = 799; rs = 0; re = 479;
    #12;
    checks++;
    if (col_add !== 10'd0 || row_add !== 9'd0 || frame_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_state col=%0d row=%0d fd=%0b expected 0/0/0", col_add, row_add, frame_done);
    end
    checks++;
    if (col_cnt_end !== 1'b0 || row_cnt_end !== 1'b0) begin
      failures++;
      $display("FAIL reset_ends col_end=%0b row_end=%0b expected 0/0", col_cnt_end, row_cnt_end);
    end
    @(negedge osc_clk);
    RST = 1'b1;
    m_col = 0; m_row = 0; m_fd = 0;
    repeat (3) clk_step();
    checks++;
    if (col_add !== 10'd0 || row_add !== 9'd0 || frame_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_release col=%0d row=%0d fd=%0b expected 0/0/0", col_add, row_add, frame_done);
    end
  endtask

  task automatic test_scan(input bit md, input string nm);
    int ec[7], er[7];
    if (!md) begin
      ec = '{2, 3, 4, 2, 3, 4, 2};
      er = '{1, 1, 1, 2, 2, 2, 1};
    end else begin
      ec = '{2, 2, 3, 3, 4, 4, 2};
      er = '{1, 2, 1, 2, 1, 2, 1};
    end
    mode = md; cs = 2; ce = 4; rs = 1; re = 2;
    upd = 1; inc = 0;
    clk_step();
    upd = 0;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) begin
        inc = 1;
        clk_step();
      end
      checks++;
      if (int'(col_add) != ec[i] || int'(row_add) != er[i] || frame_done !== (FD_EN && i == 6)) begin
        failures++;
        $display("FAIL %s step%0d got (%0d,%0d) fd=%0b expected (%0d,%0d) fd=%0b", nm, i,
                 col_add, row_add, frame_done, ec[i], er[i], FD_EN && i == 6);
      end
    end
    inc = 0;
    clk_step();
  endtask

  task automatic test_update_priority();
    mode = 0; cs = 2; ce = 4; rs = 1; re = 2;
    upd = 1; inc = 0;
    clk_step();
    upd = 0; inc = 1;
    repeat (4) clk_step();  // (3,1),(4,1),(2,2),(3,2)
    checks++;
    if (col_add !== 10'd3 || row_add !== 9'd2) begin
      failures++;
      $display("FAIL upd_setup got (%0d,%0d) expected (3,2)", col_add, row_add);
    end
    upd = 1; inc = 1;
    clk_step();
    checks++;
    if (col_add !== 10'd2 || row_add !== 9'd1 || frame_done !== 1'b0) begin
      failures++;
      $display("FAIL upd_and_step got (%0d,%0d) fd=%0b expected (2,1) fd=0", col_add, row_add, frame_done);
    end
    upd = 0; inc = 0;
    repeat (2) clk_step();
    checks++;
    if (col_add !== 10'd2 || row_add !== 9'd1) begin
      failures++;
      $display("FAIL hold got (%0d,%0d) expected (2,1)", col_add, row_add);
    end
  endtask

  task automatic test_wrap();
    int ec[5];
    ec = '{1022, 1023, 0, 1, 1022};
    mode = 0; cs = 1022; ce = 1; rs = 0; re = 0;
    upd = 1; inc = 0;
    clk_step();
    upd = 0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        inc = 1;
        clk_step();
      end
      checks++;
      if (int'(col_add) != ec[i] || row_add !== 9'd0 || frame_done !== (FD_EN && i == 4)) begin
        failures++;
        $display("FAIL wrap step%0d got (%0d,%0d) fd=%0b expected (%0d,0) fd=%0b", i,
                 col_add, row_add, frame_done, ec[i], FD_EN && i == 4);
      end
    end
    inc = 0;
    clk_step();
  endtask

  task automatic test_pad();
    ext_oe = 0; dq_oe = 1; dq_out = 16'hA5C3;
    #1;
    checks++;
    if (DATA !== 16'hA5C3 || dq_in !== 16'hA5C3) begin
      failures++;
      $display("FAIL pad_drive DATA=%h dq_in=%h expected a5c3", DATA, dq_in);
    end
    dq_oe = 0;
    #1;
    ext_oe = 1; ext_val = 16'h1234;
    #1;
    checks++;
    if (DATA !== 16'h1234 || dq_in !== 16'h1234) begin
      failures++;
      $display("FAIL pad_read DATA=%h dq_in=%h expected 1234", DATA, dq_in);
    end
    ext_val = 16'h5A0F;
    #1;
    checks++;
    if (dq_in !== 16'h5A0F) begin
      failures++;
      $display("FAIL pad_follow dq_in=%h expected 5a0f", dq_in);
    end
    ext_oe = 0;
    #1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 31) == 0 || n == 0) begin
        cs   = 10'($urandom);
        ce   = 10'(cs + 10'($urandom_range(0, 4)));
        rs   = 9'($urandom);
        re   = 9'(rs + 9'($urandom_range(0, 3)));
        mode = 1'($urandom);
      end
      upd = (n == 0) || ($urandom_range(0, 39) == 0);
      inc = ($urandom_range(0, 3) != 0);
      #1;
      checks++;
      if (col_cnt_end !== (m_col == int'(ce)) || row_cnt_end !== (m_row == int'(re))) begin
        failures++;
        $display("FAIL rnd_ends n=%0d got %0b/%0b expected %0b/%0b", n, col_cnt_end, row_cnt_end,
                 m_col == int'(ce), m_row == int'(re));
      end
      clk_step();
      checks++;
      if (int'(col_add) != m_col || int'(row_add) != m_row || frame_done !== m_fd) begin
        failures++;
        $display("FAIL rnd_addr n=%0d got (%0d,%0d) fd=%0b expected (%0d,%0d) fd=%0b", n,
                 col_add, row_add, frame_done, m_col, m_row, m_fd);
      end
    end
    upd = 0; inc = 0;
  endtask

  task automatic test_reset_mid();
    mode = 0; cs = 5; ce = 9; rs = 3; re = 6;
    upd = 1; inc = 0;
    clk_step();
    upd = 0; inc = 1;
    repeat (3) clk_step();
    inc = 0;
    #2;
    RST = 1'b0;
    #1;
    checks++;
    if (col_add !== 10'd0 || row_add !== 9'd0 || frame_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid got (%0d,%0d) fd=%0b expected (0,0) fd=0", col_add, row_add, frame_done);
    end
    @(negedge osc_clk);
    RST = 1'b1;
    m_col = 0; m_row = 0; m_fd = 0;
    repeat (4) clk_step();
    checks++;
    if (col_add !== 10'd0 || row_add !== 9'd0) begin
      failures++;
      $display("FAIL reset_no_reload got (%0d,%0d) expected (0,0)", col_add, row_add);
    end
  endtask

  initial begin
    test_reset();
    test_scan(1'b0, "scan_mode0");
    test_scan(1'b1, "scan_mode1");
    test_update_priority();
    test_wrap();
    test_pad();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL timeout checks=%0d", checks);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tft_user_scan_io.md
# tft_user_scan_io

TFT user-side address scanner and data-pad block. It merges the 16-bit bidirectional host data pad with a 10-bit column counter and a 9-bit row counter. The counters walk a programmable rectangular window in column-major or row-major order. It sits between the host-bus command decoder, which supplies window bounds, mode and pad control, and the SDRAM/FIFO pixel path, which consumes `col_add`/`row_add` and issues `startup_inc` steps.

## Interface
- No parameters. Widths are fixed: data 16, column 10, row 9.
- `osc_clk` in 1: system clock, rising edge.
- `RST` in 1: reset, asynchronous, active-low.
- `DATA` inout 16: host data pad.
- `dq_oe` in 1: 1 = drive `DATA`.
- `dq_out` in 16: value driven on `DATA` when `dq_oe`=1.
- `dq_in` out 16: pad read-back.
- `col_add_S`, `col_add_E` in 10: column window start/end.
- `row_add_S`, `row_add_E` in 9: row window start/end.
- `update_col_row_add` in 1: load both counters with their start values.
- `row_col_inc` in 1: 0 = column-fast (row-major raster); 1 = row-fast.
- `startup_inc` in 1: one address step per cycle while high.
- `col_add` out 10, `row_add` out 9: current address.
- `col_cnt_end`, `row_cnt_end` out 1: counter equals its end value (combinational).
- `frame_done` out 1: registered one-cycle pulse after the last window address is stepped.

## Operation
- Pad: `DATA` = `dq_out` when `dq_oe`=1, else high-Z. `dq_in` = `DATA` always (combinational, no register).
- `col_cnt_end` = (`col_add` == `col_add_E`). `row_cnt_end` = (`row_add` == `row_add_E`).
- `col_en` = (~`row_col_inc` | `row_cnt_end`) & `startup_inc`.
- `row_en` = (`row_col_inc` | `col_cnt_end`) & `startup_inc`.
- `col_ld` = `update_col_row_add` | (`col_cnt_end` & `col_en`). `row_ld` = `update_col_row_add` | (`row_cnt_end` & `row_en`).
- Each counter, on every clock edge:
  - if load is high: q ← start value;
  - else if enable is high: q ← q+1, modulo 2^width (1023→0, 511→0);
  - else hold.
  - Load has priority over enable.
- Mode 0 (`row_col_inc`=0):
  - Column steps every enabled cycle.
  - At column end, the column reloads and the row steps.
  - At row end as well, the row reloads too, so the scan wraps to (S,S).
- Mode 1 (`row_col_inc`=1): the same, with the roles of row and column swapped.
- Start > end is not rejected. The counter climbs, wraps through 0 and reaches end. The decoder is responsible for ordering the bounds.
- Bound inputs are sampled live. A bound change takes effect at the next compare, with no implicit reload.

## Timing
- Reset (async assert, sync release): `col_add`=0, `row_add`=0, `frame_done`=0. Ends are combinational from reset state and bounds.
- Counter latency: 1 cycle from load/step to new `q`.
- `frame_done` = registered (`col_en` & `col_cnt_end` & `row_cnt_end`). It goes high 1 cycle after the step from (colE,rowE), coincident with the wrapped address.
- `update_col_row_add` together with `startup_inc` in the same cycle: both counters load start values; no step occurs.
- `RST` asserted mid-scan: counters clear to 0 immediately. The counters do not reload the window until `update_col_row_add` is pulsed.
- Pad direction changes in the same delta as `dq_oe`. Bus turnaround is the decoder's responsibility.

## Configuration
- Macro `USER_SCAN_FRAME_DONE_EN`.
- Defined: `frame_done` is generated as above.
- Undefined: the `frame_done` port remains but is tied to 0, and its flop and logic are removed. The counters are unaffected.

## Test plan
- Reset → `col_add`=0, `row_add`=0, `frame_done`=0. With `col_add_E`=799 and `row_add_E`=479: `col_cnt_end`=0, `row_cnt_end`=0.
- Mode 0, window col 2..4, row 1..2: pulse update, then hold `startup_inc` → (2,1),(3,1),(4,1),(2,2),(3,2),(4,2),(2,1). `frame_done`=1 only in the cycle showing the final (2,1).
- Mode 1, same window: update, then step → (2,1),(2,2),(3,1),(3,2),(4,1),(4,2),(2,1). `frame_done` pulses once.
- Update and step in the same cycle while at (3,2) → next (2,1), no increment. `startup_inc`=0 → address holds.
- Bounds `col_add_S`=1022, `col_add_E`=1, row S=E=0, mode 0 → columns 1022,1023,0,1,1022. `frame_done` pulses after column 1.
- `dq_oe`=1, `dq_out`=16'hA5C3 → `DATA`=A5C3 and `dq_in`=A5C3. `dq_oe`=0 with an external driver of 16'h1234 → `DATA` not driven by the block, `dq_in`=1234.
